seg7_reader: RTL and testbench

Recovers hex digits from a time-multiplexed, active-low 7-segment display bus. It is the inverse of the team's hex-to-7-segment decoder, using the same segment map and polarity. It sits between a scanned display bus (internal loopback or external pins) and any logic that needs to check the displayed value, such as self-checking lab harnesses or display monitors. Each scan slot is qualified by a stability counter, decoded back to a 4-bit nibble, and the nibbles are assembled into a frame.

---
 rtl/seg7_reader.sv | 159 +++++++++++++++
 tb/tb_seg7_reader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_reader.sv
// seg7_reader: recovers hex nibbles from a scanned, active-low 7-segment bus.
//
// Each scan slot must hold steady for STABLE sampled cycles before it is
// decoded and captured into its digit position. A capture is taken only once
// per hold. Once every position has been captured, a one-cycle frame_valid
// pulse is issued together with the OR of the per-digit error flags.
//
// Ports:
//   clk          clock
//   resetn       asynchronous active-low reset
//   seg_n        segment bus, active-low, bit0=a .. bit6=g
//   dig_sel      one-hot digit-position select
//   digit        recovered nibbles, digit[4i+3:4i] belongs to dig_sel[i]
//   digit_err    per-position illegal-glyph flag from the last capture
//   frame_valid  one-cycle pulse when all positions have been captured
//   frame_err    OR of digit_err at frame_valid, held until the next pulse
module seg7_reader #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned STABLE = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   digit,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid,
  output logic                  frame_err
);

  localparam int unsigned CntW = $clog2(STABLE) + 1;

  typedef enum logic {StWait, StHeld} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [6:0]          s_seg;
  logic [DIGITS-1:0]   s_sel;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [4*DIGITS-1:0] digit_d;
  logic [DIGITS-1:0]   err_d;
  logic                frame_valid_d, frame_err_d;

  logic                match, sel_ok, capture;
  logic [3:0]          glyph_val;
  logic                glyph_ok;
  logic [DIGITS-1:0]   seen_next;
  logic                frame_done;

  // The registered sample is the "previous" one; the incoming bus value is
  // compared against it so that a value settling before edge k is captured
  // at edge k+STABLE.
  assign match  = (seg_n == s_seg) && (dig_sel == s_sel);
  assign sel_ok = $onehot(s_sel);

  always_comb begin
    glyph_ok  = 1'b1;
    glyph_val = 4'h0;
    unique case (s_seg)
      7'h40: glyph_val = 4'h0;
      7'h79: glyph_val = 4'h1;
      7'h24: glyph_val = 4'h2;
      7'h30: glyph_val = 4'h3;
      7'h19: glyph_val = 4'h4;
      7'h12: glyph_val = 4'h5;
      7'h02: glyph_val = 4'h6;
      7'h78: glyph_val = 4'h7;
      7'h00: glyph_val = 4'h8;
      7'h18: glyph_val = 4'h9;
      7'h08: glyph_val = 4'hA;
      7'h03: glyph_val = 4'hB;
      7'h46: glyph_val = 4'hC;
      7'h21: glyph_val = 4'hD;
      7'h06: glyph_val = 4'hE;
      7'h0E: glyph_val = 4'hF;
      default: begin
        glyph_ok  = 1'b0;
        glyph_val = 4'h0;
      end
    endcase
  end

  // Stability FSM: one capture per steady hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StWait: begin
        if (!sel_ok || !match) begin
          cnt_d = '0;
        end else if (cnt_q == CntW'(STABLE - 1)) begin
          capture = 1'b1;
          state_d = StHeld;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHeld: begin
        if (!match) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StWait;
        cnt_d   = '0;
      end
    endcase
  end

  // Capture datapath and frame assembly.
  always_comb begin
    digit_d = digit;
    err_d   = digit_err;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (capture && s_sel[i]) begin
        digit_d[4*i +: 4] = glyph_val;
        err_d[i]          = ~glyph_ok;
      end
    end
    seen_next     = seen_q | s_sel;
    frame_done    = capture && (&seen_next);
    seen_d        = seen_q;
    if (frame_done) begin
      seen_d = '0;
    end else if (capture) begin
      seen_d = seen_next;
    end
    frame_valid_d = frame_done;
    frame_err_d   = frame_done ? (|err_d) : frame_err;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StWait;
      cnt_q       <= '0;
      s_seg       <= 7'h7F;
      s_sel       <= '0;
      seen_q      <= '0;
      digit       <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_seg       <= seg_n;
      s_sel       <= dig_sel;
      seen_q      <= seen_d;
      digit       <= digit_d;
      digit_err   <= err_d;
      frame_valid <= frame_valid_d;
      frame_err   <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed self-checking bench for seg7_reader (DIGITS=4, STABLE=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seg7_reader;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [6:0]  seg_n = 7'h7F;
  logic [3:0]  dig_sel = 4'b0000;
  logic [15:0] digit;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        frame_err;

  int n_vec = 0;
  int n_err = 0;
  int fv_cnt = 0;
  int fv_base;

  seg7_reader #(
    .DIGITS (4),
    .STABLE (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .seg_n       (seg_n),
    .dig_sel     (dig_sel),
    .digit       (digit),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // frame_valid is stable before each rising edge, so count pulses there.
  always @(posedge clk) if (frame_valid) fv_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [6:0] s, input logic [3:0] d);
    seg_n   = s;
    dig_sel = d;
  endtask

  task automatic do_reset();
    drive(7'h7F, 4'b0000);
    resetn = 1'b0;
    #1;
    step(2);
    resetn = 1'b1;
    step(1);
  endtask

  initial begin
    // Reset values
    step(2);
    check_eq("rst_digit", 32'(digit), 32'h0);
    check_eq("rst_err", 32'(digit_err), 32'h0);
    check_eq("rst_fv", 32'(frame_valid), 32'h0);
    check_eq("rst_ferr", 32'(frame_err), 32'h0);
    resetn = 1'b1;
    step(1);

    // Single slot: load 1 into position 0, then recapture as 0 with exact latency
    drive(7'h79, 4'b0001);
    step(6);
    check_eq("pre_pos0", 32'(digit[3:0]), 32'h1);
    drive(7'h40, 4'b0001);
    step(4);
    check_eq("lat_before", 32'(digit[3:0]), 32'h1);
    step(1);
    check_eq("lat_at", 32'(digit[3:0]), 32'h0);
    check_eq("lat_err", 32'(digit_err[0]), 32'h0);
    step(5);
    check_eq("single_nofv", 32'(fv_cnt), 32'h0);

    // Reset mid-frame: positions 0 and 1 captured, then reset
    drive(7'h24, 4'b0010);
    step(6);
    check_eq("mid_pos1", 32'(digit[7:4]), 32'h2);
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_digit", 32'(digit), 32'h0);
    check_eq("mid_rst_fv", 32'(frame_valid), 32'h0);
    drive(7'h7F, 4'b0000);
    step(2);
    resetn = 1'b1;
    step(1);
    fv_base = fv_cnt;
    drive(7'h30, 4'b0100);
    step(6);
    drive(7'h08, 4'b1000);
    step(6);
    check_eq("mid_partial", 32'(digit), 32'hA300);
    check_eq("mid_nofv", 32'(fv_cnt - fv_base), 32'h0);

    // Full frame
    do_reset();
    fv_base = fv_cnt;
    drive(7'h79, 4'b0001);
    step(6);
    drive(7'h24, 4'b0010);
    step(6);
    drive(7'h30, 4'b0100);
    step(6);
    drive(7'h08, 4'b1000);
    step(4);
    check_eq("ff_fv_early", 32'(frame_valid), 32'h0);
    step(1);
    check_eq("ff_fv_pulse", 32'(frame_valid), 32'h1);
    check_eq("ff_digit", 32'(digit), 32'hA321);
    check_eq("ff_ferr", 32'(frame_err), 32'h0);
    step(1);
    check_eq("ff_fv_drop", 32'(frame_valid), 32'h0);
    step(4);
    check_eq("ff_fv_once", 32'(fv_cnt - fv_base), 32'h1);

    // Glitch rejection on position 2
    drive(7'h12, 4'b0100);
    step(6);
    check_eq("gl_pre", 32'(digit[11:8]), 32'h5);
    drive(7'h40, 4'b0100);
    step(2);
    drive(7'h79, 4'b0100);
    step(2);
    check_eq("gl_no1", 32'(digit[11:8]), 32'h5);
    drive(7'h40, 4'b0100);
    step(4);
    check_eq("gl_wait", 32'(digit[11:8]), 32'h5);
    step(1);
    check_eq("gl_cap", 32'(digit[11:8]), 32'h0);

    // Illegal glyph at position 3, then complete the frame
    fv_base = fv_cnt;
    drive(7'h7F, 4'b1000);
    step(5);
    check_eq("ill_nib", 32'(digit[15:12]), 32'h0);
    check_eq("ill_err", 32'(digit_err), 32'h8);
    drive(7'h79, 4'b0001);
    step(6);
    drive(7'h24, 4'b0010);
    step(5);
    check_eq("ill_fv", 32'(frame_valid), 32'h1);
    check_eq("ill_ferr", 32'(frame_err), 32'h1);
    check_eq("ill_digit", 32'(digit), 32'h0021);
    step(1);
    check_eq("ill_ferr_hold", 32'(frame_err), 32'h1);
    check_eq("ill_fv_once", 32'(fv_cnt - fv_base), 32'h1);

    // Bad select: multiple bits, then none, mid-frame after position 0 captured
    drive(7'h02, 4'b0001);
    step(6);
    check_eq("bs_pre", 32'(digit), 32'h0026);
    fv_base = fv_cnt;
    drive(7'h40, 4'b0011);
    step(20);
    drive(7'h19, 4'b0000);
    step(20);
    check_eq("bs_digit", 32'(digit), 32'h0026);
    check_eq("bs_err", 32'(digit_err), 32'h8);
    check_eq("bs_nofv", 32'(fv_cnt - fv_base), 32'h0);
    // Seen must still hold position 0 only: positions 1..3 complete the frame
    drive(7'h78, 4'b0010);
    step(6);
    drive(7'h18, 4'b0100);
    step(6);
    check_eq("bs_seen_nofv", 32'(fv_cnt - fv_base), 32'h0);
    drive(7'h0E, 4'b1000);
    step(5);
    check_eq("bs_seen_fv", 32'(frame_valid), 32'h1);
    check_eq("bs_final", 32'(digit), 32'hF976);
    check_eq("bs_final_ferr", 32'(frame_err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
